demux_top: RTL and testbench

- 1-to-4 demultiplexer block that exposes three independently implemented routing paths with identical function, for cross-checking:
  - WIDTH-bit enable-gated demux
  - WIDTH-bit if/else-style demux
  - 1-bit demux
- Shared select and enable.
- Outputs registered on one clock with an asynchronous active-low reset.
- Used as a basic routing/verification building block.

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_top_demux4_reg.sv | 62 ++++++
 rtl/demux_top.sv | 125 ++++++++++++
 tb/tb_demux_top.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
//
// Shared constants for the demux_top routing block.
//   DEFAULT_WIDTH : default data width of the multi-bit routing paths
//   SEL0..SEL3    : destination indices carried on the 2-bit select bus
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [1:0] SEL0 = 2'd0;
    localparam logic [1:0] SEL1 = 2'd1;
    localparam logic [1:0] SEL2 = 2'd2;
    localparam logic [1:0] SEL3 = 2'd3;

    localparam int unsigned NUM_DEST = 4;

endpackage : demux_pkg

// File: rtl/demux_top_demux4_reg.sv
// ---------------------------------------------------------------------------
// demux4_reg
//
// Parameterized 1-to-4 registered demultiplexer.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears all outputs
//   select    : destination index 0..3
//   enable    : 1 = route din to dout[select], 0 = all outputs zero
//   din       : data to route
//   dout0..3  : registered outputs, one cycle latency
//
// Only the selected output carries data; the other three are driven to zero
// every cycle, so at most one output is nonzero at any time.
// ---------------------------------------------------------------------------
module demux4_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       select,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3
);

    logic [WIDTH-1:0] dout_d [NUM_DEST];
    logic [WIDTH-1:0] dout_q [NUM_DEST];

    // Each destination is gated by its own decode term, so a change on
    // select/enable/din all land together at the next edge.
    always_comb begin
        for (int i = 0; i < NUM_DEST; i++) begin
            dout_d[i] = '0;
            if (enable && (select == 2'(i))) begin
                dout_d[i] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DEST; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DEST; i++) begin
                dout_q[i] <= dout_d[i];
            end
        end
    end

    assign dout0 = dout_q[0];
    assign dout1 = dout_q[1];
    assign dout2 = dout_q[2];
    assign dout3 = dout_q[3];

endmodule : demux4_reg

// File: rtl/demux_top.sv
// ---------------------------------------------------------------------------
// demux_top
//
// 1-to-4 routing block with three independently built paths of identical
// function, intended for cross-checking one against another.
//   clk              : rising-edge clock
//   rst_n            : asynchronous active-low reset, clears all outputs
//   select           : destination index 0..3 (shared by all paths)
//   enable           : 1 = route, 0 = all outputs zero (shared)
//   in               : WIDTH-bit data for the enable-gated and if/else paths
//   in_1             : 1-bit data for the out_demux path
//   out_enable0..3   : enable-gated demux outputs (demux4_reg instance)
//   out_if_else0..3  : if/else-chain demux outputs (coded locally)
//   out_demux0..3    : 1-bit demux outputs (demux4_reg instance, WIDTH=1)
//
// All outputs are registered with one cycle of latency. There is no state
// other than the output registers.
// ---------------------------------------------------------------------------
module demux_top
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       select,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    input  logic             in_1,
    output logic [WIDTH-1:0] out_enable0,
    output logic [WIDTH-1:0] out_enable1,
    output logic [WIDTH-1:0] out_enable2,
    output logic [WIDTH-1:0] out_enable3,
    output logic [WIDTH-1:0] out_if_else0,
    output logic [WIDTH-1:0] out_if_else1,
    output logic [WIDTH-1:0] out_if_else2,
    output logic [WIDTH-1:0] out_if_else3,
    output logic             out_demux0,
    output logic             out_demux1,
    output logic             out_demux2,
    output logic             out_demux3
);

    // -----------------------------------------------------------------------
    // Enable-gated multi-bit path
    // -----------------------------------------------------------------------
    demux4_reg #(
        .WIDTH (WIDTH)
    ) u_enable_path (
        .clk    (clk),
        .rst_n  (rst_n),
        .select (select),
        .enable (enable),
        .din    (in),
        .dout0  (out_enable0),
        .dout1  (out_enable1),
        .dout2  (out_enable2),
        .dout3  (out_enable3)
    );

    // -----------------------------------------------------------------------
    // 1-bit path
    // -----------------------------------------------------------------------
    demux4_reg #(
        .WIDTH (1)
    ) u_bit_path (
        .clk    (clk),
        .rst_n  (rst_n),
        .select (select),
        .enable (enable),
        .din    (in_1),
        .dout0  (out_demux0),
        .dout1  (out_demux1),
        .dout2  (out_demux2),
        .dout3  (out_demux3)
    );

    // -----------------------------------------------------------------------
    // If/else multi-bit path
    //
    // Deliberately written as a priority if/else chain on select rather than
    // reusing demux4_reg, so a decode bug in one structure shows up as a
    // disagreement with the other.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] if_else0_d, if_else1_d, if_else2_d, if_else3_d;
    logic [WIDTH-1:0] if_else0_q, if_else1_q, if_else2_q, if_else3_q;

    always_comb begin
        if_else0_d = '0;
        if_else1_d = '0;
        if_else2_d = '0;
        if_else3_d = '0;
        if (enable) begin
            if (select == SEL0) begin
                if_else0_d = in;
            end else if (select == SEL1) begin
                if_else1_d = in;
            end else if (select == SEL2) begin
                if_else2_d = in;
            end else begin
                if_else3_d = in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_else0_q <= '0;
            if_else1_q <= '0;
            if_else2_q <= '0;
            if_else3_q <= '0;
        end else begin
            if_else0_q <= if_else0_d;
            if_else1_q <= if_else1_d;
            if_else2_q <= if_else2_d;
            if_else3_q <= if_else3_d;
        end
    end

    assign out_if_else0 = if_else0_q;
    assign out_if_else1 = if_else1_q;
    assign out_if_else2 = if_else2_q;
    assign out_if_else3 = if_else3_q;

endmodule : demux_top

// File: tb/tb_demux_top.sv
// ---------------------------------------------------------------------------
// tb_demux_top
//
// Directed table of {inputs, expected outputs}, hand-written sequences for
// reset behaviour, and a randomized run against a small reference model.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_demux_top;

    localparam int W = 4;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   select;
    logic         enable;
    logic [W-1:0] in;
    logic         in_1;
    logic [W-1:0] out_enable0, out_enable1, out_enable2, out_enable3;
    logic [W-1:0] out_if_else0, out_if_else1, out_if_else2, out_if_else3;
    logic         out_demux0, out_demux1, out_demux2, out_demux3;

    always #5 clk = ~clk;

    demux_top #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .select       (select),
        .enable       (enable),
        .in           (in),
        .in_1         (in_1),
        .out_enable0  (out_enable0),
        .out_enable1  (out_enable1),
        .out_enable2  (out_enable2),
        .out_enable3  (out_enable3),
        .out_if_else0 (out_if_else0),
        .out_if_else1 (out_if_else1),
        .out_if_else2 (out_if_else2),
        .out_if_else3 (out_if_else3),
        .out_demux0   (out_demux0),
        .out_demux1   (out_demux1),
        .out_demux2   (out_demux2),
        .out_demux3   (out_demux3)
    );

    // Packed views: index 3 in the top nibble/bit.
    logic [4*W-1:0] en_bus, ie_bus;
    logic [3:0]     bit_bus;
    assign en_bus  = {out_enable3, out_enable2, out_enable1, out_enable0};
    assign ie_bus  = {out_if_else3, out_if_else2, out_if_else1, out_if_else0};
    assign bit_bus = {out_demux3, out_demux2, out_demux1, out_demux0};

    // -----------------------------------------------------------------------
    // Scoreboard counters and compare
    // -----------------------------------------------------------------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [4*W-1:0] exp_wide, input logic [3:0] exp_bit);
        check({name, ".out_enable"},  32'(en_bus),  32'(exp_wide));
        check({name, ".out_if_else"}, 32'(ie_bus),  32'(exp_wide));
        check({name, ".out_demux"},   32'(bit_bus), 32'(exp_bit));
    endtask

    // -----------------------------------------------------------------------
    // Driver
    // -----------------------------------------------------------------------
    task automatic drive(input logic [1:0] s, input logic e, input logic [W-1:0] d, input logic d1);
        select = s;
        enable = e;
        in     = d;
        in_1   = d1;
    endtask

    // -----------------------------------------------------------------------
    // Directed vector table
    // -----------------------------------------------------------------------
    typedef struct {
        string          name;
        logic [1:0]     sel;
        logic           en;
        logic [W-1:0]   din;
        logic           din1;
        logic [4*W-1:0] exp_wide;
        logic [3:0]     exp_bit;
    } vec_t;

    vec_t vecs[$];

    // Reference model for the randomized run.
    logic [4*W-1:0] exp_q[$];
    logic [3:0]     exp_bit_q[$];

    initial begin
        // Select sweep
        vecs.push_back('{"sweep0", 2'd0, 1'b1, 4'b1010, 1'b1, 16'h000A, 4'b0001});
        vecs.push_back('{"sweep1", 2'd1, 1'b1, 4'b1010, 1'b1, 16'h00A0, 4'b0010});
        vecs.push_back('{"sweep2", 2'd2, 1'b1, 4'b1010, 1'b1, 16'h0A00, 4'b0100});
        vecs.push_back('{"sweep3", 2'd3, 1'b1, 4'b1010, 1'b1, 16'hA000, 4'b1000});
        // Enable gating
        vecs.push_back('{"gate_off", 2'd3, 1'b0, 4'b1010, 1'b1, 16'h0000, 4'b0000});
        vecs.push_back('{"gate_on",  2'd3, 1'b1, 4'b1010, 1'b1, 16'hA000, 4'b1000});
        // Data change with select
        vecs.push_back('{"data0", 2'd0, 1'b1, 4'b1100, 1'b1, 16'h000C, 4'b0001});
        vecs.push_back('{"data1", 2'd1, 1'b1, 4'b0011, 1'b1, 16'h0030, 4'b0010});
        vecs.push_back('{"data2", 2'd2, 1'b1, 4'b1111, 1'b1, 16'h0F00, 4'b0100});
        vecs.push_back('{"data3", 2'd3, 1'b1, 4'b0001, 1'b1, 16'h1000, 4'b1000});
        // in_1 = 0 on the bit path while the wide paths still route
        vecs.push_back('{"in1_zero", 2'd1, 1'b1, 4'b0101, 1'b0, 16'h0050, 4'b0000});
        // Simultaneous change of everything, then enable drop with new data
        vecs.push_back('{"simul0", 2'd2, 1'b0, 4'b1111, 1'b1, 16'h0000, 4'b0000});
        vecs.push_back('{"simul1", 2'd0, 1'b1, 4'b0110, 1'b1, 16'h0006, 4'b0001});
        vecs.push_back('{"simul2", 2'd3, 1'b1, 4'b1001, 1'b0, 16'h9000, 4'b0000});

        // Reset from time zero
        rst_n = 1'b0;
        drive(2'd2, 1'b1, 4'b1111, 1'b1);
        #1;
        check_all("reset_initial", 16'h0000, 4'b0000);
        @(posedge clk);
        #1;
        check_all("reset_held_over_edge", 16'h0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].sel, vecs[i].en, vecs[i].din, vecs[i].din1);
            @(posedge clk);
            #1;
            check_all(vecs[i].name, vecs[i].exp_wide, vecs[i].exp_bit);
        end

        // Hold: outputs stay put until the next edge even if inputs move.
        @(negedge clk);
        drive(2'd0, 1'b1, 4'b0111, 1'b1);
        #2;
        check_all("hold_between_edges", 16'h9000, 4'b0000);

        // Mid-run asynchronous reset with pending enable=1, select=2, in=1111
        @(negedge clk);
        drive(2'd2, 1'b1, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        check_all("pre_reset_load", 16'h0F00, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset_clear", 16'h0000, 4'b0000);
        @(posedge clk);
        #1;
        check_all("reset_hold_edge", 16'h0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset_load", 16'h0F00, 4'b0100);

        // Randomized cross-check against the reference model
        for (int c = 0; c < 200; c++) begin
            logic [1:0]   rs;
            logic         re;
            logic [W-1:0] rd;
            logic         rd1;
            @(negedge clk);
            rs  = 2'($urandom_range(0, 3));
            re  = 1'($urandom_range(0, 3) != 0);
            rd  = W'($urandom_range(0, 15));
            rd1 = 1'($urandom_range(0, 1));
            drive(rs, re, rd, rd1);
            exp_q.push_back(re ? ({{(3*W){1'b0}}, rd} << (W * rs)) : '0);
            exp_bit_q.push_back(re ? (4'(rd1) << rs) : 4'b0000);
            @(posedge clk);
            #1;
            begin
                logic [4*W-1:0] ew;
                logic [3:0]     eb;
                ew = exp_q.pop_front();
                eb = exp_bit_q.pop_front();
                check("rand.enable_vs_if_else", 32'(en_bus), 32'(ie_bus));
                check_all("rand", ew, eb);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_demux_top
